// File: rtl/ispm_way_scrub_ctrl_pkg.sv
// ============================================================================
// Module      : ispm_way_scrub_ctrl_pkg
// Description : Shared types and helpers for the I-SPM way scrub controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ispm_way_scrub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SCRUB = 2'd2,
        DONE  = 2'd3
    } spm_scrub_state_t;

    // Lines per way: index space minus the byte-offset bits of one line.
    function automatic int unsigned scrub_num_lines(input int unsigned idx_width,
                                                    input int unsigned line_width);
        return 32'd1 << (idx_width - $clog2(line_width / 8));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ispm_way_scrub_ctrl.sv
// ============================================================================
// Module      : ispm_way_scrub_ctrl
// Description : Withdraws reconfigured I-cache ways, drains SPM traffic,
//               zeroes every line of those ways and publishes the new mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ispm_way_scrub_ctrl
    import ispm_way_scrub_ctrl_pkg::*;
#(
    parameter int unsigned        NR_WAYS      = 4,
    parameter int unsigned        LINE_WIDTH   = 128,
    parameter int unsigned        MEMORY_WIDTH = 173,
    parameter int unsigned        IDX_WIDTH    = 12,
    parameter int unsigned        ADDR_WIDTH   = 64,
    parameter logic [NR_WAYS-1:0] RESET_WAYS   = '0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              cfg_valid_i,
    input  logic [NR_WAYS-1:0]                                cfg_ways_i,
    output logic                                              cfg_ready_o,
    output logic                                              cfg_done_o,
    output logic                                              busy_o,
    input  logic                                              spm_idle_i,
    output logic [NR_WAYS-1:0]                                active_ways_o,
    input  logic                                              mem_gnt_i,
    output logic [NR_WAYS-1:0]                                req_o,
    output logic [NR_WAYS-1:0][ADDR_WIDTH-1:0]                addr_o,
    output logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0]              wdata_o,
    output logic [NR_WAYS-1:0]                                we_o,
    output logic [NR_WAYS-1:0][((MEMORY_WIDTH+7)/8)-1:0]      be_o
);

    localparam int unsigned c_NUM_LINES = scrub_num_lines(IDX_WIDTH, LINE_WIDTH);
    localparam int unsigned c_LINE_BITS = $clog2(c_NUM_LINES);
    localparam int unsigned c_BE_WIDTH  = (MEMORY_WIDTH + 7) / 8;
    localparam logic [c_LINE_BITS-1:0] c_LAST_LINE = c_LINE_BITS'(c_NUM_LINES - 1);
    localparam logic [c_LINE_BITS-1:0] c_LINE_ONE  = c_LINE_BITS'(1);

    spm_scrub_state_t         r_state;
    logic [NR_WAYS-1:0]       r_active;
    logic [NR_WAYS-1:0]       r_target;
    logic [NR_WAYS-1:0]       r_chg;
    logic [c_LINE_BITS-1:0]   r_line;

    logic [NR_WAYS-1:0]       w_chg;
    logic                     w_scrub;
    logic [ADDR_WIDTH-1:0]    w_addr;

    assign w_chg   = cfg_ways_i ^ r_active;
    assign w_scrub = (r_state == SCRUB);
    assign w_addr  = ADDR_WIDTH'(r_line);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_active <= RESET_WAYS;
            r_target <= '0;
            r_chg    <= '0;
            r_line   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        if (w_chg == '0) begin
                            r_state <= DONE;
                        end else begin
                            // Changed ways leave service before any scrub write.
                            r_target <= cfg_ways_i;
                            r_chg    <= w_chg;
                            r_active <= r_active & ~w_chg;
                            r_state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (spm_idle_i) begin
                        r_line  <= '0;
                        r_state <= SCRUB;
                    end
                end
                SCRUB: begin
                    if (mem_gnt_i) begin
                        r_line <= r_line + c_LINE_ONE;
                        if (r_line == c_LAST_LINE) begin
                            r_active <= r_target;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o   = (r_state == IDLE);
    assign cfg_done_o    = (r_state == DONE);
    assign busy_o        = (r_state != IDLE);
    assign active_ways_o = r_active;
    assign req_o         = w_scrub ? r_chg : '0;
    assign we_o          = w_scrub ? r_chg : '0;

    // Byte enables cover the tag bits as well, so the whole entry is cleared.
    for (genvar gi = 0; gi < NR_WAYS; gi++) begin : g_way
        assign addr_o[gi]  = w_addr;
        assign wdata_o[gi] = '0;
        assign be_o[gi]    = {c_BE_WIDTH{w_scrub}};
    end

endmodule

`default_nettype wire

// File: doc/ispm_way_scrub_ctrl.md
# ispm_way_scrub_ctrl

Sequences reconfiguration of instruction-cache ways between cache and SPM mode and owns the `active_ways` mask consumed by the I-SPM controller. On every configuration change it:
- withdraws the affected ways from service;
- waits for in-flight SPM traffic to drain;
- zeroes every line of those ways (data and tag) through a granted memory write port;
- publishes the new mask.

It sits between the CSR that holds the requested SPM-way set and the I-SPM controller / way-memory arbiter.

## Interface
Parameters:
- NR_WAYS, 4, number of cache ways
- LINE_WIDTH, 128, usable line bits per way entry
- MEMORY_WIDTH, 173, physical way-entry width including tag
- IDX_WIDTH, 12, cache index plus byte offset; lines per way NUM_LINES = 2^(IDX_WIDTH - log2(LINE_WIDTH/8)) = 256 at defaults
- ADDR_WIDTH, 64, way-memory address width
- RESET_WAYS, '0, value of active_ways_o after reset

Ports:
- clk_i  in  1  clock; only clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  new requested SPM-way mask valid
- cfg_ways_i  in  NR_WAYS  requested SPM-way mask
- cfg_ready_o  out  1  request accepted when cfg_valid_i && cfg_ready_o
- cfg_done_o  out  1  one-cycle pulse, new mask in effect
- busy_o  out  1  high in every state except IDLE
- spm_idle_i  in  1  no outstanding fetch/LSU SPM access
- active_ways_o  out  NR_WAYS  ways usable as SPM
- mem_gnt_i  in  1  arbiter grants the scrub write this cycle
- req_o  out  NR_WAYS  per-way memory request
- addr_o  out  NR_WAYS x ADDR_WIDTH  line address, same for all ways
- wdata_o  out  NR_WAYS x MEMORY_WIDTH  always zero
- we_o  out  NR_WAYS  write enable
- be_o  out  NR_WAYS x ceil(MEMORY_WIDTH/8)  byte enables

## Operation
- Registers:
  - active_q: NR_WAYS bits
  - target_q: NR_WAYS bits
  - chg_q: NR_WAYS bits
  - line_q: log2(NUM_LINES) bits
  - state_q
- States:
  - IDLE: cfg_ready_o=1. On accept, compute chg = cfg_ways_i ^ active_q.
    - chg==0: go to DONE, mask unchanged.
    - chg!=0: on the clock edge set target_q=cfg_ways_i and chg_q=chg, and set active_q to active_q & ~chg (clears the changed ways only). Go to DRAIN.
  - DRAIN: hold until spm_idle_i=1, then line_q=0 and go to SCRUB.
  - SCRUB: outputs while in this state:
    - req_o = chg_q
    - we_o = chg_q
    - be_o all ones, so the tag is zeroed too
    - wdata_o = 0
    - addr_o = line_q zero-extended

    On mem_gnt_i, line_q+1. When the grant arrives with line_q = NUM_LINES-1, set active_q=target_q and go to DONE. Without a grant, outputs hold and line_q does not advance.
  - DONE: cfg_done_o=1 for exactly one cycle, then go to IDLE.
- Outside SCRUB: req_o, we_o, be_o are all 0.
- active_ways_o = active_q at all times (registered).
- Ways leaving SPM are also scrubbed, so no SPM data leaks into cache mode.
- cfg_valid_i while not in IDLE: not accepted (cfg_ready_o=0). The requester holds it.
- line_q wrap-around: never occurs; the exit transition happens on the last grant.

## Timing
- Reset: state IDLE, active_ways_o=RESET_WAYS, cfg_ready_o=1, all other outputs 0.
- Reset mid-scrub: same reset values, scrub abandoned; software re-issues the request.
- Accept at edge 0 (rising edge ending the accept cycle):
  - From cycle 1: active_ways_o reduced and busy_o=1.
  - spm_idle_i=1 in cycle 1: SCRUB from cycle 2.
  - With continuous grants: last write in cycle 257, DONE and new mask in cycle 258, IDLE in cycle 259.
- No-change request: DONE in cycle 1, IDLE in cycle 2.
- Outputs req_o/addr_o/be_o are combinational from state_q, line_q and chg_q only; no combinational path from mem_gnt_i.

## Structure
- Add the state typedef to wt_cache_pkg as spm_scrub_state_t {IDLE, DRAIN, SCRUB, DONE}.
- Compute NUM_LINES locally from parameters.
- No sub-module. Use the common_cells registers macros with synchronous active-high reset.

## Test plan
- Reset then cfg_ways_i=4'b0011 with spm_idle_i=1 and mem_gnt_i=1: 512 way writes (256 per way), addr 0..255, req_o=4'b0011; active_ways_o=4'b0011 and cfg_done_o in cycle 258.
- From active 4'b0011, request 4'b0110: active_ways_o=4'b0010 from cycle 1; ways 0 and 2 scrubbed; final mask 4'b0110.
- Request equal to the current mask: no req_o activity, cfg_done_o in cycle 1.
- spm_idle_i low for 5 cycles and mem_gnt_i toggling 1/0: SCRUB begins 1 cycle after spm_idle_i rises; line_q advances only on grants; no address skipped or repeated.
- Assert rst_i at line 100 of a scrub: next cycle IDLE, active_ways_o=RESET_WAYS, req_o=0, cfg_ready_o=1.
- Issue cfg_valid_i during SCRUB: cfg_ready_o=0; the held request is accepted in the IDLE cycle after cfg_done_o.
